// File: rtl/mmio_bus_ctrl.sv
// CPU-to-MMIO bus sequencer: decodes the access target, holds the one-hot select until the
// target is ready or the timeout expires, then retires the access for one cycle.
module mmio_bus_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic [3:0]  dev_sel,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [3:0]  dev_ready,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] gpio0_rdata,
    input  logic [31:0] uart_rdata,
    input  logic [31:0] i2c_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [3:0] decode_target(input logic [31:0] addr);
        logic [3:0] sel;
        sel = 4'b0000;
        if (addr[31:25] == 7'b0000001) begin
            sel = 4'b0001;
        end else if (addr == 32'h0400_0000) begin
            sel = 4'b0010;
        end else if ((addr >= 32'h0400_0004) && (addr <= 32'h0400_0009)) begin
            sel = 4'b0100;
        end else if ((addr >= 32'h0400_000A) && (addr <= 32'h0400_000F)) begin
            sel = 4'b1000;
        end else begin
            sel = 4'b0000;
        end
        return sel;
    endfunction

    state_t         state_r, next_state_s;
    logic [CW-1:0]  count_r, next_count_s;
    logic [3:0]     target_s, next_sel_s;
    logic [31:0]    sel_rdata_s, done_rdata_s;
    logic           done_err_s, latch_s, stall_s;

    // Read data of the currently selected target
    always_comb begin
        sel_rdata_s = 32'h0000_0000;
        case (dev_sel)
            4'b0001: sel_rdata_s = dmem_rdata;
            4'b0010: sel_rdata_s = gpio0_rdata;
            4'b0100: sel_rdata_s = uart_rdata;
            4'b1000: sel_rdata_s = i2c_rdata;
            default: sel_rdata_s = 32'h0000_0000;
        endcase
    end

    // Next-state, select, timeout counter and completion values
    always_comb begin
        next_state_s = state_r;
        next_count_s = count_r;
        next_sel_s   = 4'b0000;
        target_s     = 4'b0000;
        done_rdata_s = 32'h0000_0000;
        done_err_s   = 1'b0;
        latch_s      = 1'b0;
        stall_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) begin
                    latch_s  = 1'b1;
                    stall_s  = 1'b1;
                    target_s = decode_target(cpu_addr);
                    if (target_s != 4'b0000) begin
                        next_state_s = ST_ACCESS;
                        next_sel_s   = target_s;
                        next_count_s = {CW{1'b0}};
                    end else begin
                        // Unmapped: retire immediately with an error, never touch the bus
                        next_state_s = ST_DONE;
                        done_err_s   = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                stall_s = 1'b1;
                if ((dev_sel & dev_ready) != 4'b0000) begin
                    next_state_s = ST_DONE;
                    done_rdata_s = bus_we ? 32'h0000_0000 : sel_rdata_s;
                end else if (count_r == LAST_CNT) begin
                    next_state_s = ST_DONE;
                    done_err_s   = 1'b1;
                end else begin
                    next_state_s = ST_ACCESS;
                    next_sel_s   = dev_sel;
                    next_count_s = count_r + CW'(1);
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, select, completion and bus latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            count_r   <= {CW{1'b0}};
            dev_sel   <= 4'b0000;
            cpu_rdata <= 32'h0000_0000;
            cpu_err   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0000_0000;
            bus_wdata <= 32'h0000_0000;
        end else begin
            state_r   <= next_state_s;
            count_r   <= next_count_s;
            dev_sel   <= next_sel_s;
            cpu_rdata <= done_rdata_s;
            cpu_err   <= done_err_s;
            if (latch_s) begin
                bus_we    <= cpu_we;
                bus_addr  <= cpu_addr;
                bus_wdata <= cpu_wdata;
            end
        end
    end

    // Stall must fall with reset even while the CPU still holds its request
    assign cpu_stall = ~reset & stall_s;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Randomized bench for mmio_bus_ctrl: a transaction-level model predicts every output each
// cycle; literal pins on select/stall/error cycle counts anchor the directed scenarios.
module tb_mmio_bus_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall, cpu_err;
    logic [3:0]  dev_sel;
    logic        bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  dev_ready;
    logic [31:0] rd_in [4];

    always #5 clk = ~clk;

    mmio_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .dev_sel(dev_sel), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .dev_ready(dev_ready),
        .dmem_rdata(rd_in[0]), .gpio0_rdata(rd_in[1]), .uart_rdata(rd_in[2]), .i2c_rdata(rd_in[3])
    );

    int          checks = 0;
    int          errors = 0;
    logic        exp_stall = 1'b0, exp_err = 1'b0, exp_bus_we = 1'b0;
    logic [3:0]  exp_sel = 4'b0000;
    logic [31:0] exp_rdata = 32'h0, exp_bus_addr = 32'h0, exp_bus_wdata = 32'h0;

    int          sel_cnt = 0, stall_cnt = 0, err_cnt = 0;
    int          base_sel = 0, base_stall = 0, base_err = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        pin_req = 1'b0;
    int          pin_which = 0;
    string       pin_name = "";
    logic [31:0] pin_exp = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare process: every cycle against the model, plus requested literal pins
    always @(negedge clk) begin
        chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, exp_stall});
        chk("dev_sel",   {28'b0, dev_sel},   {28'b0, exp_sel});
        chk("cpu_rdata", cpu_rdata,          exp_rdata);
        chk("cpu_err",   {31'b0, cpu_err},   {31'b0, exp_err});
        chk("bus_we",    {31'b0, bus_we},    {31'b0, exp_bus_we});
        chk("bus_addr",  bus_addr,           exp_bus_addr);
        chk("bus_wdata", bus_wdata,          exp_bus_wdata);
        sel_cnt   = sel_cnt + ((dev_sel != 4'b0000) ? 1 : 0);
        stall_cnt = stall_cnt + (cpu_stall ? 1 : 0);
        err_cnt   = err_cnt + (cpu_err ? 1 : 0);
        if (cpu_rdata != 32'h0) last_rdata = cpu_rdata;
        if (pin_req) begin
            case (pin_which)
                0: begin base_sel = sel_cnt; base_stall = stall_cnt; base_err = err_cnt; end
                1: chk(pin_name, 32'(sel_cnt - base_sel), pin_exp);
                2: chk(pin_name, 32'(stall_cnt - base_stall), pin_exp);
                3: chk(pin_name, last_rdata, pin_exp);
                default: chk(pin_name, 32'(err_cnt - base_err), pin_exp);
            endcase
        end
    end

    // Address map as plain ranges: 0..3 target index, -1 unmapped
    function automatic int target_of(input logic [31:0] a);
        if (a >= 32'h0200_0000 && a <= 32'h03FF_FFFF) return 0;
        if (a == 32'h0400_0000) return 1;
        if (a >= 32'h0400_0004 && a <= 32'h0400_0009) return 2;
        if (a >= 32'h0400_000A && a <= 32'h0400_000F) return 3;
        return -1;
    endfunction

    task automatic set_out(input logic s, input logic [3:0] sel, input logic [31:0] rd, input logic e);
        exp_stall = s; exp_sel = sel; exp_rdata = rd; exp_err = e;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic rand_rd();
        for (int i = 0; i < 4; i++) rd_in[i] = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
            dev_ready = 4'($urandom);
            set_out(1'b0, 4'b0000, 32'h0, 1'b0);
            next_cycle();
        end
    endtask

    task automatic pin(input string nm, input int which, input logic [31:0] e);
        cpu_req = 1'b0;
        set_out(1'b0, 4'b0000, 32'h0, 1'b0);
        pin_name = nm; pin_which = which; pin_exp = e; pin_req = 1'b1;
        next_cycle();
        pin_req = 1'b0;
    endtask

    // One CPU access; ready_at = ACCESS cycle index where the target's ready rises (-1 never)
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int ready_at, input bit rnd_rd, input logic [3:0] noise_or,
                              input int abort_at);
        int          t;
        logic [31:0] d_rd;
        logic        d_err;
        bit          done;
        t = target_of(addr);
        d_rd = 32'h0; d_err = 1'b0; done = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        dev_ready = 4'($urandom);
        if (rnd_rd) rand_rd();
        set_out(1'b1, 4'b0000, 32'h0, 1'b0);
        next_cycle();
        exp_bus_we = we; exp_bus_addr = addr; exp_bus_wdata = wdata;
        if (t < 0) begin
            d_err = 1'b1;
        end else begin
            for (int k = 0; k < TIMEOUT && !done; k++) begin
                cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
                dev_ready = 4'($urandom) | noise_or;
                dev_ready[t] = (ready_at >= 0) && (k >= ready_at);
                if (rnd_rd) rand_rd();
                set_out(1'b1, 4'(1 << t), 32'h0, 1'b0);
                if (k == abort_at) begin
                    #2;
                    reset = 1'b1;
                    set_out(1'b0, 4'b0000, 32'h0, 1'b0);
                    exp_bus_we = 1'b0; exp_bus_addr = 32'h0; exp_bus_wdata = 32'h0;
                    next_cycle();
                    return;
                end
                if (dev_ready[t]) begin
                    d_rd = we ? 32'h0 : rd_in[t];
                    done = 1'b1;
                end else if (k == TIMEOUT - 1) begin
                    d_err = 1'b1;
                    done = 1'b1;
                end
                next_cycle();
            end
        end
        set_out(1'b0, 4'b0000, d_rd, d_err);
        next_cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return 32'h0200_0000 | ($urandom & 32'h01FF_FFFF);
            1: return 32'h0400_0000;
            2: return 32'h0400_0004 + 32'($urandom_range(0, 5));
            3: return 32'h0400_000A + 32'($urandom_range(0, 5));
            default: begin
                case ($urandom_range(0, 2))
                    0: return 32'h0400_0001 + 32'($urandom_range(0, 2));
                    1: return 32'h0400_0010 + 32'($urandom_range(0, 255));
                    default: return $urandom;
                endcase
            end
        endcase
    endfunction

    initial begin
        int r, ra;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dev_ready = 4'b0000;
        for (int i = 0; i < 4; i++) rd_in[i] = 32'h0;
        repeat (2) next_cycle();
        reset = 1'b0;
        idle(2);

        // dmem read with ready already high
        pin("mark", 0, 32'h0);
        rd_in[0] = 32'hDEAD_BEEF; rd_in[1] = 32'h1111_1111; rd_in[2] = 32'h2222_2222; rd_in[3] = 32'h3333_3333;
        run_access(1'b0, 32'h0200_0010, 32'h0, 0, 1'b0, 4'b0000, -1);
        pin("t1_sel_cycles", 1, 32'd1);
        pin("t1_stall_cycles", 2, 32'd2);
        pin("t1_rdata", 3, 32'hDEAD_BEEF);
        pin("t1_err_cycles", 4, 32'd0);

        // uart write, ready after 3 ACCESS cycles
        pin("mark", 0, 32'h0);
        run_access(1'b1, 32'h0400_0006, 32'h55, 3, 1'b1, 4'b0000, -1);
        pin("t2_sel_cycles", 1, 32'd4);
        pin("t2_stall_cycles", 2, 32'd5);
        pin("t2_err_cycles", 4, 32'd0);

        // unmapped read
        pin("mark", 0, 32'h0);
        run_access(1'b0, 32'h0400_0010, 32'h0, 0, 1'b1, 4'b0000, -1);
        pin("t3_sel_cycles", 1, 32'd0);
        pin("t3_stall_cycles", 2, 32'd1);
        pin("t3_err_cycles", 4, 32'd1);

        // i2c timeout while the dmem ready bit is held high
        pin("mark", 0, 32'h0);
        run_access(1'b0, 32'h0400_000C, 32'h0, -1, 1'b1, 4'b0001, -1);
        pin("t4_sel_cycles", 1, 32'd15);
        pin("t4_stall_cycles", 2, 32'd16);
        pin("t4_err_cycles", 4, 32'd1);

        // ready arriving on the last permitted cycle still succeeds
        pin("mark", 0, 32'h0);
        run_access(1'b0, 32'h0400_0008, 32'h0, TIMEOUT - 1, 1'b1, 4'b0000, -1);
        pin("edge_sel_cycles", 1, 32'd15);
        pin("edge_err_cycles", 4, 32'd0);

        // reset in the middle of a gpio0 access, then a clean dmem read
        run_access(1'b0, 32'h0400_0000, 32'h0, -1, 1'b1, 4'b0000, 2);
        cpu_req = 1'b0; reset = 1'b0;
        idle(1);
        pin("mark", 0, 32'h0);
        run_access(1'b0, 32'h0200_0000, 32'h0, 0, 1'b1, 4'b0000, -1);
        pin("t5_sel_cycles", 1, 32'd1);
        pin("t5_stall_cycles", 2, 32'd2);

        // back-to-back gpio0 read then dmem write
        pin("mark", 0, 32'h0);
        run_access(1'b0, 32'h0400_0000, 32'h0, 0, 1'b1, 4'b0000, -1);
        run_access(1'b1, 32'h0200_0000, 32'hCAFE_F00D, 0, 1'b1, 4'b0000, -1);
        pin("t6_sel_cycles", 1, 32'd2);
        pin("t6_stall_cycles", 2, 32'd4);
        pin("t6_err_cycles", 4, 32'd0);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                6:       ra = -1;
                7:       ra = TIMEOUT - 1;
                8:       ra = TIMEOUT;
                9:       ra = 0;
                default: ra = r;
            endcase
            run_access(1'($urandom), rand_addr(), $urandom, ra, 1'b1, 4'b0000, -1);
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
